// File: rtl/debug_pipeline_ctrl.sv
// Debug controller: runs, steps and halts the MIPS pipeline from UART command bytes and
// dumps the register bank LSB first. Define DBG_CYCLE_COUNT_EN to append a 32-bit enabled-cycle count.
module debug_pipeline_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NB_REGS    = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  input  logic [7:0]            i_cmd,
  output logic                  o_cmd_ready,
  input  logic                  i_halt_detected,
  output logic                  o_pipe_enable,
  output logic [ADDR_WIDTH-1:0] o_dbg_reg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_reg_data,
  output logic                  o_tx_valid,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_ready,
  output logic                  o_halted,
  output logic                  o_busy
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int BYTE_WN = $clog2(BYTES + 1);
  localparam int BYTE_W  = (BYTE_WN < 3) ? 3 : BYTE_WN;
  localparam logic [BYTE_W-1:0]     LAST_BYTE = BYTE_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NB_REGS - 1);

  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_STOP = 8'h68;
  localparam logic [7:0] CMD_DUMP = 8'h72;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DUMP_ADDR,
    DUMP_LOAD,
    DUMP_BYTE
`ifdef DBG_CYCLE_COUNT_EN
    , DUMP_CNT
`endif
  } state_t;

  state_t                r_state;
  logic                  r_pipeEnable;
  logic [ADDR_WIDTH-1:0] r_dbgAddr;
  logic [ADDR_WIDTH-1:0] r_regIdx;
  logic [BYTE_W-1:0]     r_byteIdx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_txValid;
  logic                  r_halted;

  logic w_cmdReady;
  logic w_cmdAccept;
  logic w_lastByte;

  assign w_cmdReady  = (r_state == IDLE) || (r_state == RUN);
  assign w_cmdAccept = i_cmd_valid && w_cmdReady;

`ifdef DBG_CYCLE_COUNT_EN
  logic [31:0] r_cycleCnt;
  logic        r_cntPhase;

  // The trailing counter word is always 4 bytes, independent of DATA_WIDTH.
  assign w_lastByte = r_cntPhase ? (r_byteIdx == BYTE_W'(3)) : (r_byteIdx == LAST_BYTE);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cycleCnt <= 32'd0;
    end else if (r_pipeEnable) begin
      r_cycleCnt <= r_cycleCnt + 32'd1;
    end
  end
`else
  assign w_lastByte = (r_byteIdx == LAST_BYTE);
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_pipeEnable <= 1'b0;
      r_dbgAddr    <= '0;
      r_regIdx     <= '0;
      r_byteIdx    <= '0;
      r_shift      <= '0;
      r_txValid    <= 1'b0;
      r_halted     <= 1'b0;
`ifdef DBG_CYCLE_COUNT_EN
      r_cntPhase   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmdAccept) begin
            case (i_cmd)
              CMD_RUN: begin
                if (!r_halted) begin
                  r_state      <= RUN;
                  r_pipeEnable <= 1'b1;
                end
              end
              CMD_STEP: begin
                if (!r_halted) begin
                  r_state      <= STEP;
                  r_pipeEnable <= 1'b1;
                end
              end
              CMD_DUMP: r_state <= DUMP_ADDR;
              default:  ;
            endcase
          end
        end
        // A HALT pulse wins over a simultaneous stop command so o_halted is still set.
        RUN: begin
          if (i_halt_detected || (w_cmdAccept && (i_cmd == CMD_STOP))) begin
            r_state      <= DUMP_ADDR;
            r_pipeEnable <= 1'b0;
            if (i_halt_detected) r_halted <= 1'b1;
          end
        end
        STEP: begin
          r_state      <= DUMP_ADDR;
          r_pipeEnable <= 1'b0;
          if (i_halt_detected) r_halted <= 1'b1;
        end
        DUMP_ADDR: begin
          r_dbgAddr <= r_regIdx;
          r_state   <= DUMP_LOAD;
        end
        DUMP_LOAD: begin
          r_shift   <= i_dbg_reg_data;
          r_byteIdx <= '0;
          r_txValid <= 1'b1;
          r_state   <= DUMP_BYTE;
        end
        DUMP_BYTE: begin
          if (i_tx_ready) begin
            r_shift   <= r_shift >> 8;
            r_byteIdx <= r_byteIdx + 1'b1;
            if (w_lastByte) begin
              r_txValid <= 1'b0;
`ifdef DBG_CYCLE_COUNT_EN
              if (r_cntPhase) begin
                r_cntPhase <= 1'b0;
                r_state    <= IDLE;
              end else if (r_regIdx == LAST_REG) begin
                r_regIdx  <= '0;
                r_dbgAddr <= '0;
                r_state   <= DUMP_CNT;
              end else begin
                r_regIdx <= r_regIdx + 1'b1;
                r_state  <= DUMP_ADDR;
              end
`else
              if (r_regIdx == LAST_REG) begin
                r_regIdx  <= '0;
                r_dbgAddr <= '0;
                r_state   <= IDLE;
              end else begin
                r_regIdx <= r_regIdx + 1'b1;
                r_state  <= DUMP_ADDR;
              end
`endif
            end
          end
        end
`ifdef DBG_CYCLE_COUNT_EN
        DUMP_CNT: begin
          r_shift    <= DATA_WIDTH'(r_cycleCnt);
          r_byteIdx  <= '0;
          r_txValid  <= 1'b1;
          r_cntPhase <= 1'b1;
          r_state    <= DUMP_BYTE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready    = w_cmdReady;
  assign o_pipe_enable  = r_pipeEnable;
  assign o_dbg_reg_addr = r_dbgAddr;
  assign o_tx_valid     = r_txValid;
  assign o_tx_data      = r_shift[7:0];
  assign o_halted       = r_halted;
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_debug_pipeline_ctrl.sv
// Directed bench for debug_pipeline_ctrl: step, run/halt, stalled TX, mid-dump reset,
// stop/halt collision and ignored commands. Extra counter checks when DBG_CYCLE_COUNT_EN is defined.
module tb_debug_pipeline_ctrl;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int BPR = DW / 8;
`ifdef DBG_CYCLE_COUNT_EN
  localparam int DUMP_LEN = NR * BPR + 4;
`else
  localparam int DUMP_LEN = NR * BPR;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmdValid = 1'b0;
  logic [7:0]    cmd = 8'h00;
  logic          cmdReady;
  logic          haltDetected = 1'b0;
  logic          pipeEnable;
  logic [AW-1:0] dbgRegAddr;
  logic [DW-1:0] dbgRegData;
  logic          txValid;
  logic [7:0]    txData;
  logic          txReady = 1'b1;
  logic          halted;
  logic          busy;

  logic [DW-1:0] regFile [NR];
  logic [7:0]    gotBytes [DUMP_LEN];
  int            gotCount;
  int            checkCount = 0;
  int            errorCount = 0;
  int            enableCycles = 0;

  always #5 clock = ~clock;

  debug_pipeline_ctrl #(.DATA_WIDTH(DW), .NB_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .i_clock(clock),
    .i_reset(reset),
    .i_cmd_valid(cmdValid),
    .i_cmd(cmd),
    .o_cmd_ready(cmdReady),
    .i_halt_detected(haltDetected),
    .o_pipe_enable(pipeEnable),
    .o_dbg_reg_addr(dbgRegAddr),
    .i_dbg_reg_data(dbgRegData),
    .o_tx_valid(txValid),
    .o_tx_data(txData),
    .i_tx_ready(txReady),
    .o_halted(halted),
    .o_busy(busy)
  );

  // Register bank model with a combinational debug read port.
  assign dbgRegData = regFile[dbgRegAddr];

  // Counts clock cycles during which the pipeline enable was high.
  always @(posedge clock) if (pipeEnable) enableCycles++;

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] expectedByte(input int idx, input logic [31:0] cnt);
    logic [DW-1:0] w;
    if (idx < NR * BPR) w = regFile[idx / BPR];
    else w = DW'(cnt);
    return w[8 * (idx % BPR) +: 8];
  endfunction

  // Presents one command byte at a negedge and holds it until accepted.
  task automatic applyStimulus(input logic [7:0] c);
    int waitCycles = 0;
    @(negedge clock);
    cmdValid = 1'b1;
    cmd = c;
    while (!cmdReady && waitCycles < 400) begin
      @(negedge clock);
      waitCycles++;
    end
    checkOutput("cmd_accept", cmdReady, 1'b1);
    @(negedge clock);
    cmdValid = 1'b0;
  endtask

  // Receives n bytes, checking that a stalled byte stays stable and the pipeline stays gated.
  task automatic collectDump(input int n, input bit randomReady);
    int cycles = 0;
    int stableErrors = 0;
    int enableSeen = 0;
    logic prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;
    gotCount = 0;
    while (gotCount < n && cycles < 3000) begin
      @(negedge clock);
      cycles++;
      if (pipeEnable) enableSeen++;
      if (prevStall && (!txValid || txData !== prevData)) stableErrors++;
      txReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (txValid && txReady) begin
        gotBytes[gotCount] = txData;
        gotCount++;
      end
      prevStall = txValid && !txReady;
      prevData = txData;
    end
    checkOutput("dump_len", gotCount, n);
    checkOutput("dump_stable", stableErrors, 0);
    checkOutput("dump_no_enable", enableSeen, 0);
  endtask

  task automatic compareDump(input int n, input bit withCnt, input logic [31:0] cnt);
    for (int i = 0; i < n; i++) begin
      if (i < NR * BPR || withCnt)
        checkOutput($sformatf("dump_byte%0d", i), gotBytes[i], expectedByte(i, cnt));
    end
  endtask

  initial begin
    int en0;
    int seen;
    int budget;
    int validSeen;

    for (int k = 0; k < NR; k++)
      regFile[k] = {8'(k * 4 + 3) ^ 8'hA0, 8'(k * 4 + 2), 8'(k * 4 + 1) ^ 8'h5A, 8'(k * 4)};
    regFile[1] = 32'h11223344;

    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst_pipe_enable", pipeEnable, 1'b0);
    checkOutput("rst_tx_valid", txValid, 1'b0);
    checkOutput("rst_tx_data", txData, 8'h00);
    checkOutput("rst_reg_addr", dbgRegAddr, 5'd0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_cmd_ready", cmdReady, 1'b1);
    reset = 1'b1;

    $display("[TB] single step");
    en0 = enableCycles;
    applyStimulus(8'h73);
    checkOutput("step_enable_high", pipeEnable, 1'b1);
    checkOutput("step_cmd_ready", cmdReady, 1'b0);
    collectDump(DUMP_LEN, 1'b0);
    compareDump(DUMP_LEN, 1'b0, 32'd0);
    checkOutput("step_reg1_b0", gotBytes[4], 8'h44);
    checkOutput("step_reg1_b1", gotBytes[5], 8'h33);
    checkOutput("step_reg1_b2", gotBytes[6], 8'h22);
    checkOutput("step_reg1_b3", gotBytes[7], 8'h11);
    @(negedge clock);
    checkOutput("step_busy_done", busy, 1'b0);
    checkOutput("step_valid_done", txValid, 1'b0);
    checkOutput("step_addr_done", dbgRegAddr, 5'd0);
    checkOutput("step_enable_cycles", enableCycles - en0, 1);

    $display("[TB] run until halt");
    en0 = enableCycles;
    applyStimulus(8'h63);
    seen = 0;
    budget = 0;
    while (seen < 10 && budget < 100) begin
      if (pipeEnable) seen++;
      @(negedge clock);
      budget++;
    end
    checkOutput("run_enabled_before_halt", pipeEnable, 1'b1);
    haltDetected = 1'b1;
    @(negedge clock);
    haltDetected = 1'b0;
    checkOutput("run_enable_dropped", pipeEnable, 1'b0);
    checkOutput("run_halted", halted, 1'b1);
    checkOutput("run_busy", busy, 1'b1);
    checkOutput("run_enable_cycles", enableCycles - en0, 11);
    collectDump(DUMP_LEN, 1'b0);
    compareDump(DUMP_LEN, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("run_busy_done", busy, 1'b0);

    en0 = enableCycles;
    applyStimulus(8'h63);
    repeat (3) @(negedge clock);
    checkOutput("halted_run_ignored", busy, 1'b0);
    applyStimulus(8'h73);
    repeat (3) @(negedge clock);
    checkOutput("halted_step_ignored", busy, 1'b0);
    checkOutput("halted_no_enable", enableCycles - en0, 0);
    checkOutput("halted_sticky", halted, 1'b1);

    $display("[TB] dump with random TX backpressure");
    applyStimulus(8'h72);
    collectDump(DUMP_LEN, 1'b1);
    compareDump(DUMP_LEN, 1'b0, 32'd0);
    @(negedge clock);
    txReady = 1'b1;
    checkOutput("bp_busy_done", busy, 1'b0);

    $display("[TB] reset mid-dump");
    applyStimulus(8'h72);
    collectDump(50, 1'b0);
    compareDump(50, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("mid_valid_before_reset", txValid, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_valid", txValid, 1'b0);
    checkOutput("mid_reset_busy", busy, 1'b0);
    checkOutput("mid_reset_halted", halted, 1'b0);
    checkOutput("mid_reset_addr", dbgRegAddr, 5'd0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(8'h72);
    collectDump(DUMP_LEN, 1'b0);
    compareDump(DUMP_LEN, 1'b0, 32'd0);
    @(negedge clock);

    $display("[TB] stop command together with halt pulse");
    applyStimulus(8'h63);
    repeat (2) @(negedge clock);
    checkOutput("both_cmd_ready", cmdReady, 1'b1);
    haltDetected = 1'b1;
    cmdValid = 1'b1;
    cmd = 8'h68;
    @(negedge clock);
    haltDetected = 1'b0;
    cmdValid = 1'b0;
    checkOutput("both_enable_dropped", pipeEnable, 1'b0);
    checkOutput("both_halted", halted, 1'b1);
    collectDump(DUMP_LEN, 1'b0);
    compareDump(DUMP_LEN, 1'b0, 32'd0);
    validSeen = 0;
    repeat (20) begin
      @(negedge clock);
      if (txValid || busy) validSeen++;
    end
    checkOutput("both_single_dump", validSeen, 0);

    $display("[TB] ignored commands in IDLE");
    applyStimulus(8'h55);
    checkOutput("idle_55_busy", busy, 1'b0);
    checkOutput("idle_55_ready", cmdReady, 1'b1);
    applyStimulus(8'h68);
    checkOutput("idle_h_busy", busy, 1'b0);
    checkOutput("idle_h_ready", cmdReady, 1'b1);

`ifdef DBG_CYCLE_COUNT_EN
    $display("[TB] cycle counter");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      applyStimulus(8'h73);
      collectDump(DUMP_LEN, 1'b0);
      @(negedge clock);
    end
    compareDump(DUMP_LEN, 1'b1, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/debug_pipeline_ctrl.md
Name: debug_pipeline_ctrl

Overview:
- Debug controller that sequences the 5-stage MIPS pipeline from a byte-command stream (UART RX side) and returns machine state as a byte stream (UART TX side).
- Gates the pipeline with a global enable, supporting continuous run, single-step and halt.
- After each stop it dumps the register bank through the bank's dedicated debug read port, LSB first.
- Sits between the UART and the top-level pipeline.

Parameters:
DATA_WIDTH, 32, register width; must be a multiple of 8
NB_REGS, 32, number of registers dumped, register 0 first
ADDR_WIDTH, 5, width of the register debug address

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_cmd_valid  in  1  command byte valid
i_cmd  in  8  command byte: 0x63 'c' run, 0x73 's' step, 0x68 'h' stop, 0x72 'r' dump
o_cmd_ready  out  1  command accepted when i_cmd_valid && o_cmd_ready
i_halt_detected  in  1  HALT instruction has reached WB (1-cycle pulse)
o_pipe_enable  out  1  global pipeline enable (PC, stage registers, register-bank write)
o_dbg_reg_addr  out  ADDR_WIDTH  register bank debug read address
i_dbg_reg_data  in  DATA_WIDTH  combinational read data for o_dbg_reg_addr
o_tx_valid  out  1  TX byte valid
o_tx_data  out  8  TX byte
i_tx_ready  in  1  TX consumer ready
o_halted  out  1  sticky: program reached HALT
o_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, RUN, STEP, DUMP_ADDR, DUMP_LOAD, DUMP_BYTE. The optional feature adds DUMP_CNT.
- Reset (async, i_reset=0): state IDLE, o_pipe_enable=0, o_tx_valid=0, o_tx_data=0, o_dbg_reg_addr=0, o_halted=0, byte/register indices 0, shift register 0.
  - o_tx_valid drops immediately, including mid-dump; no partial byte is later resent.
- o_cmd_ready: 1 in IDLE and RUN; 0 in all other states.
- IDLE, accepted byte:
  - 'c' → RUN.
  - 's' → STEP.
  - 'r' → DUMP_ADDR.
  - 'h' or unknown bytes are consumed and ignored.
  - If o_halted=1, 'c' and 's' are consumed and ignored.
- RUN:
  - o_pipe_enable=1 (registered, asserted from the cycle after entry).
  - i_halt_detected at cycle n: o_halted=1 and state DUMP_ADDR at n+1; o_pipe_enable=0 from n+1.
  - Accepted 'h' behaves the same but does not set o_halted. Other bytes in RUN are consumed and dropped.
  - Halt pulse and 'h' in the same cycle: one transition; o_halted=1.
- STEP:
  - o_pipe_enable=1 for exactly one cycle, then DUMP_ADDR.
  - i_halt_detected during that cycle sets o_halted.
- DUMP_ADDR: drive o_dbg_reg_addr=reg_idx → DUMP_LOAD.
- DUMP_LOAD: capture i_dbg_reg_data into the shift register, byte_idx=0 → DUMP_BYTE.
- DUMP_BYTE:
  - o_tx_valid=1, o_tx_data=shift[7:0]. o_tx_valid and o_tx_data stay stable until i_tx_ready.
  - On handshake: shift right by 8, byte_idx++.
  - After DATA_WIDTH/8 bytes: if reg_idx==NB_REGS-1, go to IDLE (or DUMP_CNT with the optional feature); else reg_idx++ and go to DUMP_ADDR.
  - Back-to-back handshakes are allowed: 1 byte/cycle within a register; 2 extra cycles between registers.
- Dump length without the optional feature: NB_REGS*DATA_WIDTH/8 = 128 bytes.
- Register indices: reg_idx and o_dbg_reg_addr return to 0 on dump completion. Indices never wrap mid-dump.
- o_pipe_enable is 0 in every state except RUN and STEP. No register-bank write occurs while dumping.

Optional Feature:
- Macro: DBG_CYCLE_COUNT_EN.
- With the macro:
  - A 32-bit counter increments on every cycle with o_pipe_enable=1 and wraps 0xFFFFFFFF→0. Only reset clears it.
  - After the last register, DUMP_CNT loads the counter into the shift register and sends 4 more bytes, LSB first, then → IDLE. Total dump is 132 bytes.
- Without the macro: no counter logic, no DUMP_CNT state; dump is 128 bytes.

Test Plan:
- Reset, send 's', i_tx_ready=1 constant → o_pipe_enable high exactly 1 cycle; 128 bytes out; bytes 4..7 equal reg1 LSB-first (reg1=0x11223344 → 44 33 22 11); o_busy falls after last byte.
- Send 'c', pulse i_halt_detected after 10 enabled cycles → o_pipe_enable falls the next cycle, o_halted=1, dump follows; later 'c' and 's' are consumed with no effect.
- i_tx_ready toggled randomly during dump → each byte held stable until accepted; no byte lost or duplicated; order is reg0..reg31.
- Mid-dump (byte 50), assert i_reset for 1 cycle → o_tx_valid=0 immediately; state IDLE; 'r' restarts at reg0 byte 0.
- In RUN, send 'h' in the same cycle as i_halt_detected → single dump, o_halted=1. In IDLE, 0x55 and 'h' are ignored; o_cmd_ready stays 1.
- With DBG_CYCLE_COUNT_EN: 's' three times → last 4 bytes of the third dump are 03 00 00 00; counter preset to 0xFFFFFFFF then one step → 00 00 00 00.
